mp_addsub_mod: RTL and testbench
================================

Name: mp_addsub_mod

Overview:
Parametrised, limb-serial multi-precision adder/subtractor. It is the successor to the fixed 513-bit add/sub unit and adds modular add and modular subtract modes. Operands are processed LIMB bits per cycle using a start/done handshake. The block feeds the modular-arithmetic datapath, where Montgomery and exponentiation controllers use it for final corrections.

Parameters:
WIDTH, 513, operand width in bits (in_a, in_b, modulus)
LIMB, 64, bits processed per cycle; internal padded width PW = NLIMBS*LIMB, where NLIMBS = ceil((WIDTH+1)/LIMB)

Ports:
clk  input  1  clock; all state updates on the rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
mode  input  2  00 add, 01 sub, 10 modular add, 11 modular sub; latched with start
in_a  input  WIDTH  operand A, unsigned; latched with start
in_b  input  WIDTH  operand B, unsigned; latched with start
modulus  input  WIDTH  modulus M, used in modes 1x; latched with start
result  output  WIDTH+1  result, registered
flag  output  1  mode 00: carry (result[WIDTH]); 01: borrow (A<B); 10/11: correction applied
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when result and flag are valid

Behaviour:
- Reset (async assert, sync-released internally by the flop clock edge):
  - result=0, flag=0, busy=0, done=0, FSM=IDLE.
  - Operand, counter and carry registers are cleared.
- FSM states:
  - IDLE: start=1 at edge E0 zero-extends and latches A, B, M to PW bits, latches mode, clears the limb counter and carries. Next state RUN, busy=1.
  - RUN: each edge processes limb k (LSB first), k = 0..NLIMBS-1, then shifts the operand registers right by LIMB.
    - Chain 1: s_k = A_k + B_k + c1 (add, modular add), or A_k + ~B_k + c1 with c1 initialised to 1 (sub, modular sub).
    - Chain 2, running in parallel on the same limb:
      - modular add: t_k = s_k + ~M_k + c2, c2 initialised to 1.
      - modular sub: t_k = s_k + M_k + c2, c2 initialised to 0.
    - s_k and t_k are shifted into the S and T registers. After limb NLIMBS-1 the next state is FINAL.
  - FINAL (one edge): selects and registers the output, pulses done=1, clears busy, returns to IDLE.
- Output selection in FINAL:
  - mode 00: result = S[WIDTH:0] = A+B exactly; flag = S[WIDTH].
  - mode 01: result = S[WIDTH:0] = (A-B) mod 2^(WIDTH+1); flag = ~c1_final.
  - mode 10: if c2_final=1 (S>=M) then result = T, flag=1; else result = S, flag=0.
  - mode 11: if c1_final=0 (A<B) then result = T, flag=1; else result = S, flag=0.
  - In modes 1x, result[WIDTH]=0.
- Latency:
  - start edge E0, done visible after edge E(NLIMBS+1).
  - Defaults: NLIMBS=9, so done arrives 10 cycles after the start edge. Throughput is one operation per NLIMBS+2 cycles.
- Holding: result and flag hold their value until the next FINAL or reset. done is high for exactly one cycle.
- start while busy or during FINAL: ignored; no queuing, and the in-flight operation is unaffected.
- start held high continuously: a new operation is accepted on the first IDLE edge, which is the edge after done.
- Modular precondition: A, B < M and M > 0. If violated, the result is unspecified, but timing and done behaviour are unchanged.
- Reset mid-operation: immediate return to IDLE with all outputs 0 and no done pulse. start must be reasserted.
- WIDTH+1 a multiple of LIMB: no padding.
- LIMB >= WIDTH+1: NLIMBS=1, so latency is 2 cycles.

Test Plan:
- Defaults, mode 00, A=1, B=1 -> result=2, flag=0; done exactly 10 cycles after the start edge and one cycle wide; busy high for 9 cycles.
- Mode 01: A=1, B=1 -> result=0, flag=0. Then A=0, B=1 -> result=2^514-1 (all ones), flag=1. Also the 513-bit random vectors checked against a bench reference model for add and sub.
- Mode 10, M=7: A=5, B=4 -> result=2, flag=1; A=2, B=3 -> result=5, flag=0; A=3, B=4 -> result=0, flag=1.
- Mode 11, M=7: A=2, B=5 -> result=4, flag=1; A=5, B=2 -> result=3, flag=0. Large 512-bit M with A=0, B=M-1 -> result=1.
- Control:
  - start pulses during busy -> ignored, and the first result is intact.
  - start held high -> back-to-back operations every 11 cycles.
  - resetn low mid-RUN -> outputs 0, no done, and the next operation is correct.
- Parameter sweep: WIDTH=100, LIMB=32 (NLIMBS=4, done 5 cycles after start) and WIDTH=63, LIMB=64 (NLIMBS=1, 2 cycles). Run 1000 random vectors per mode against the reference model.

Source files
------------

// File: rtl/mp_addsub_mod.sv
// Limb-serial multi-precision adder/subtractor with modular add/sub modes.
// Operands are zero-extended to PW = NLIMBS*LIMB bits and consumed LIMB bits
// per cycle, LSB limb first. Two carry chains run side by side: chain 1 forms
// S = A +/- B, chain 2 forms T = S -/+ M so the modular correction is ready
// when the last limb retires. One FINAL cycle picks S or T and registers it.
module mp_addsub_mod #(
    parameter int WIDTH = 513,
    parameter int LIMB  = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH:0]   result,
    output logic             flag,
    output logic             busy,
    output logic             done
);

    // One extra bit beyond WIDTH so the plain add keeps its carry.
    localparam int NLIMBS = (WIDTH + LIMB) / LIMB;
    localparam int PW     = NLIMBS * LIMB;
    localparam int CW     = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;
    localparam logic [CW-1:0] LAST_LIMB = CW'(NLIMBS - 1);

    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_SUB  = 2'b01;
    localparam logic [1:0] MODE_MADD = 2'b10;
    localparam logic [1:0] MODE_MSUB = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FINAL = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;

    logic [PW-1:0]   a_r;
    logic [PW-1:0]   b_r;
    logic [PW-1:0]   m_r;
    logic [PW-1:0]   s_r;
    logic [PW-1:0]   t_r;
    logic [1:0]      mode_r;
    logic [CW-1:0]   cnt_r;
    logic            c1_r;
    logic            c2_r;

    logic [WIDTH:0]  result_r;
    logic            flag_r;
    logic            busy_r;
    logic            done_r;

    logic            accept_s;
    logic            last_s;
    logic [LIMB-1:0] b_eff_s;
    logic [LIMB-1:0] m_eff_s;
    logic [LIMB:0]   sum1_s;
    logic [LIMB:0]   sum2_s;
    logic [PW-1:0]   a_shift_s;
    logic [PW-1:0]   b_shift_s;
    logic [PW-1:0]   m_shift_s;
    logic [PW-1:0]   s_shift_s;
    logic [PW-1:0]   t_shift_s;
    logic [WIDTH:0]  res_sel_s;
    logic            flag_sel_s;

    assign accept_s = (state_r == ST_IDLE) && start;
    assign last_s   = (state_r == ST_RUN) && (cnt_r == LAST_LIMB);

    // Limb datapath: chain 1 adds B or its complement, chain 2 corrects by M.
    always_comb begin
        b_eff_s = b_r[LIMB-1:0];
        m_eff_s = m_r[LIMB-1:0];
        if (mode_r[0]) begin
            b_eff_s = ~b_r[LIMB-1:0];
            m_eff_s = m_r[LIMB-1:0];
        end else begin
            b_eff_s = b_r[LIMB-1:0];
            m_eff_s = ~m_r[LIMB-1:0];
        end
        sum1_s = {1'b0, a_r[LIMB-1:0]} + {1'b0, b_eff_s} + {{LIMB{1'b0}}, c1_r};
        sum2_s = {1'b0, sum1_s[LIMB-1:0]} + {1'b0, m_eff_s} + {{LIMB{1'b0}}, c2_r};
    end

    // Operands shift right by one limb; results fill in from the top.
    generate
        if (NLIMBS > 1) begin : g_multi
            assign a_shift_s = {{LIMB{1'b0}}, a_r[PW-1:LIMB]};
            assign b_shift_s = {{LIMB{1'b0}}, b_r[PW-1:LIMB]};
            assign m_shift_s = {{LIMB{1'b0}}, m_r[PW-1:LIMB]};
            assign s_shift_s = {sum1_s[LIMB-1:0], s_r[PW-1:LIMB]};
            assign t_shift_s = {sum2_s[LIMB-1:0], t_r[PW-1:LIMB]};
        end else begin : g_single
            assign a_shift_s = '0;
            assign b_shift_s = '0;
            assign m_shift_s = '0;
            assign s_shift_s = sum1_s[LIMB-1:0];
            assign t_shift_s = sum2_s[LIMB-1:0];
        end
    endgenerate

    // Next-state logic for the IDLE -> RUN -> FINAL sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == LAST_LIMB) begin
                    state_nxt_s = ST_FINAL;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FINAL: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, limb stepping and carry tracking.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_r    <= '0;
            b_r    <= '0;
            m_r    <= '0;
            s_r    <= '0;
            t_r    <= '0;
            mode_r <= 2'b00;
            cnt_r  <= '0;
            c1_r   <= 1'b0;
            c2_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r    <= {{(PW-WIDTH){1'b0}}, in_a};
                        b_r    <= {{(PW-WIDTH){1'b0}}, in_b};
                        m_r    <= {{(PW-WIDTH){1'b0}}, modulus};
                        s_r    <= '0;
                        t_r    <= '0;
                        mode_r <= mode;
                        cnt_r  <= '0;
                        // Subtraction is A + ~B + 1; modular add subtracts M.
                        c1_r   <= mode[0];
                        c2_r   <= mode[1] & ~mode[0];
                    end
                end
                ST_RUN: begin
                    a_r  <= a_shift_s;
                    b_r  <= b_shift_s;
                    m_r  <= m_shift_s;
                    s_r  <= s_shift_s;
                    t_r  <= t_shift_s;
                    c1_r <= sum1_s[LIMB];
                    c2_r <= sum2_s[LIMB];
                    if (cnt_r == LAST_LIMB) begin
                        cnt_r <= '0;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Final selection between the raw chain-1 result and the corrected one.
    always_comb begin
        res_sel_s  = '0;
        flag_sel_s = 1'b0;
        case (mode_r)
            MODE_ADD: begin
                res_sel_s  = s_r[WIDTH:0];
                flag_sel_s = s_r[WIDTH];
            end
            MODE_SUB: begin
                res_sel_s  = s_r[WIDTH:0];
                flag_sel_s = ~c1_r;
            end
            MODE_MADD: begin
                // Carry out of S + ~M + 1 means S >= M, so subtract M.
                if (c2_r) begin
                    res_sel_s  = {1'b0, t_r[WIDTH-1:0]};
                    flag_sel_s = 1'b1;
                end else begin
                    res_sel_s  = {1'b0, s_r[WIDTH-1:0]};
                    flag_sel_s = 1'b0;
                end
            end
            MODE_MSUB: begin
                // No carry out of A + ~B + 1 means A < B, so add M back.
                if (!c1_r) begin
                    res_sel_s  = {1'b0, t_r[WIDTH-1:0]};
                    flag_sel_s = 1'b1;
                end else begin
                    res_sel_s  = {1'b0, s_r[WIDTH-1:0]};
                    flag_sel_s = 1'b0;
                end
            end
            default: begin
                res_sel_s  = '0;
                flag_sel_s = 1'b0;
            end
        endcase
    end

    // Registered outputs: result/flag hold until the next FINAL, done pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result_r <= '0;
            flag_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= (state_r == ST_FINAL);
            if (state_r == ST_FINAL) begin
                result_r <= res_sel_s;
                flag_r   <= flag_sel_s;
            end
            // busy covers the limb-processing cycles only.
            if (accept_s) begin
                busy_r <= 1'b1;
            end else if (last_s) begin
                busy_r <= 1'b0;
            end
        end
    end

    assign result = result_r;
    assign flag   = flag_r;
    assign busy   = busy_r;
    assign done   = done_r;

endmodule

// File: tb/tb_mp_addsub_mod.sv
// Scoreboard bench for mp_addsub_mod: default 513/64 instance plus 100/32 and
// 63/64 instances sharing the operand buses, each with its own start line.
`timescale 1ns/1ps
module tb_mp_addsub_mod;

    localparam int W0 = 513;
    localparam int L0 = 64;
    localparam int W1 = 100;
    localparam int L1 = 32;
    localparam int W2 = 63;
    localparam int L2 = 64;
    localparam int MW = 516;

    typedef struct {
        logic [MW-1:0] res;
        logic          flag;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [2:0]    start_v = 3'b000;
    logic [1:0]    mode = 2'b00;
    logic [W0-1:0] in_a = '0;
    logic [W0-1:0] in_b = '0;
    logic [W0-1:0] modulus = '0;
    logic [W0:0]   result0;
    logic [W1:0]   result1;
    logic [W2:0]   result2;
    logic [2:0]    flag_v;
    logic [2:0]    busy_v;
    logic [2:0]    done_v;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    mp_addsub_mod #(.WIDTH(W0), .LIMB(L0)) dut0 (
        .clk(clk), .resetn(resetn), .start(start_v[0]), .mode(mode),
        .in_a(in_a), .in_b(in_b), .modulus(modulus),
        .result(result0), .flag(flag_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    mp_addsub_mod #(.WIDTH(W1), .LIMB(L1)) dut1 (
        .clk(clk), .resetn(resetn), .start(start_v[1]), .mode(mode),
        .in_a(in_a[W1-1:0]), .in_b(in_b[W1-1:0]), .modulus(modulus[W1-1:0]),
        .result(result1), .flag(flag_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    mp_addsub_mod #(.WIDTH(W2), .LIMB(L2)) dut2 (
        .clk(clk), .resetn(resetn), .start(start_v[2]), .mode(mode),
        .in_a(in_a[W2-1:0]), .in_b(in_b[W2-1:0]), .modulus(modulus[W2-1:0]),
        .result(result2), .flag(flag_v[2]), .busy(busy_v[2]), .done(done_v[2])
    );

    function automatic logic [MW-1:0] rand_w(input int w);
        logic [MW-1:0] x;
        x = '0;
        for (int i = 0; i < MW; i += 32) x = {x[MW-33:0], 32'($urandom)};
        return x & ((MW'(1) << w) - MW'(1));
    endfunction

    // Whole-number reference model.
    function automatic exp_t ref_op(input logic [1:0] md, input logic [MW-1:0] a,
                                    input logic [MW-1:0] b, input logic [MW-1:0] m,
                                    input int w);
        exp_t          e;
        logic [MW-1:0] mask;
        logic [MW-1:0] s;
        mask   = (MW'(1) << (w + 1)) - MW'(1);
        e.res  = '0;
        e.flag = 1'b0;
        case (md)
            2'b00: begin e.res = a + b; e.flag = e.res[w]; end
            2'b01: begin e.res = (a - b) & mask; e.flag = (a < b); end
            2'b10: begin
                s = a + b;
                if (s >= m) begin e.res = s - m; e.flag = 1'b1; end
                else begin e.res = s; e.flag = 1'b0; end
            end
            default: begin
                if (a < b) begin e.res = a + m - b; e.flag = 1'b1; end
                else begin e.res = a - b; e.flag = 1'b0; end
            end
        endcase
        return e;
    endfunction

    function automatic logic [MW-1:0] get_res(input int sel);
        logic [MW-1:0] r;
        r = '0;
        case (sel)
            0:       r[W0:0] = result0;
            1:       r[W1:0] = result1;
            default: r[W2:0] = result2;
        endcase
        return r;
    endfunction

    // Present one start pulse to instance sel and record what it must return.
    task automatic drive_op(input int sel, input logic [1:0] md, input logic [MW-1:0] a,
                            input logic [MW-1:0] b, input logic [MW-1:0] m, input exp_t e);
        @(negedge clk);
        mode         = md;
        in_a         = a[W0-1:0];
        in_b         = b[W0-1:0];
        modulus      = m[W0-1:0];
        start_v      = 3'b000;
        start_v[sel] = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start_v = 3'b000;
    endtask

    // Called at the negedge after the start edge; cyc = -1 if done never shows.
    task automatic wait_done(input int sel, output int cyc, output int bcyc);
        cyc  = -1;
        bcyc = busy_v[sel] ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done_v[sel]) begin
                cyc = i;
                break;
            end
            if (busy_v[sel]) bcyc++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_total++; if (result0 !== '0) $display("FAIL reset_result0: got %h expected 0", result0); else n_pass++;
        n_total++; if (result1 !== '0) $display("FAIL reset_result1: got %h expected 0", result1); else n_pass++;
        n_total++; if (result2 !== '0) $display("FAIL reset_result2: got %h expected 0", result2); else n_pass++;
        n_total++; if (flag_v !== 3'b000) $display("FAIL reset_flag: got %b expected 000", flag_v); else n_pass++;
        n_total++; if (busy_v !== 3'b000) $display("FAIL reset_busy: got %b expected 000", busy_v); else n_pass++;
        n_total++; if (done_v !== 3'b000) $display("FAIL reset_done: got %b expected 000", done_v); else n_pass++;
        resetn = 1'b1;
    endtask

    // Directed add/sub vectors with timing checks on the default instance.
    task automatic test_add_sub();
        logic [MW-1:0] ones;
        logic [MW-1:0] av[5];
        logic [MW-1:0] bv[5];
        logic [1:0]    mv[5];
        exp_t          ev[5];
        exp_t          e;
        int            cyc;
        int            bcyc;
        ones = (MW'(1) << W0) - MW'(1);
        av = '{MW'(1), ones, ones, MW'(1), MW'(0)};
        bv = '{MW'(1), ones, MW'(1), MW'(1), MW'(1)};
        mv = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
        ev = '{'{MW'(2), 1'b0}, '{ones + ones, 1'b1}, '{ones + MW'(1), 1'b1},
               '{MW'(0), 1'b0}, '{(MW'(1) << (W0 + 1)) - MW'(1), 1'b1}};
        for (int i = 0; i < 5; i++) begin
            drive_op(0, mv[i], av[i], bv[i], MW'(0), ev[i]);
            wait_done(0, cyc, bcyc);
            e = sb.pop_front();
            n_total++; if (cyc != 10) $display("FAIL addsub_latency[%0d]: got %0d expected 10", i, cyc); else n_pass++;
            n_total++; if (bcyc != 9) $display("FAIL addsub_busy_cycles[%0d]: got %0d expected 9", i, bcyc); else n_pass++;
            n_total++; if (get_res(0) !== e.res) $display("FAIL addsub_result[%0d]: got %h expected %h", i, get_res(0), e.res); else n_pass++;
            n_total++; if (flag_v[0] !== e.flag) $display("FAIL addsub_flag[%0d]: got %b expected %b", i, flag_v[0], e.flag); else n_pass++;
            @(negedge clk);
            n_total++; if (done_v[0] !== 1'b0) $display("FAIL addsub_done_width[%0d]: got %b expected 0", i, done_v[0]); else n_pass++;
        end
    endtask

    // Modular add and sub with M=7, plus a 512-bit modulus correction.
    task automatic test_modular();
        logic [MW-1:0] bigm;
        logic [MW-1:0] av[7];
        logic [MW-1:0] bv[7];
        logic [MW-1:0] mm[7];
        logic [1:0]    mv[7];
        exp_t          ev[7];
        exp_t          e;
        int            cyc;
        int            bcyc;
        bigm = rand_w(512) | (MW'(1) << 511);
        av = '{MW'(5), MW'(2), MW'(3), MW'(2), MW'(5), MW'(0), MW'(0)};
        bv = '{MW'(4), MW'(3), MW'(4), MW'(5), MW'(2), MW'(0), bigm - MW'(1)};
        mm = '{MW'(7), MW'(7), MW'(7), MW'(7), MW'(7), MW'(7), bigm};
        mv = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
        ev = '{'{MW'(2), 1'b1}, '{MW'(5), 1'b0}, '{MW'(0), 1'b1}, '{MW'(4), 1'b1},
               '{MW'(3), 1'b0}, '{MW'(0), 1'b0}, '{MW'(1), 1'b1}};
        for (int i = 0; i < 7; i++) begin
            drive_op(0, mv[i], av[i], bv[i], mm[i], ev[i]);
            wait_done(0, cyc, bcyc);
            e = sb.pop_front();
            n_total++; if (cyc != 10) $display("FAIL mod_latency[%0d]: got %0d expected 10", i, cyc); else n_pass++;
            n_total++; if (get_res(0) !== e.res) $display("FAIL mod_result[%0d]: got %h expected %h", i, get_res(0), e.res); else n_pass++;
            n_total++; if (flag_v[0] !== e.flag) $display("FAIL mod_flag[%0d]: got %b expected %b", i, flag_v[0], e.flag); else n_pass++;
        end
    endtask

    // Random vectors in every mode against the reference model.
    task automatic test_random(input int sel, input int w, input int lat, input int n);
        logic [MW-1:0] a;
        logic [MW-1:0] b;
        logic [MW-1:0] m;
        exp_t          e;
        int            cyc;
        int            bcyc;
        for (int md = 0; md < 4; md++) begin
            for (int i = 0; i < n; i++) begin
                m = rand_w(w);
                if (m == '0) m = MW'(1);
                a = rand_w(w);
                b = rand_w(w);
                if (md >= 2) begin
                    a = a % m;
                    b = b % m;
                end
                drive_op(sel, 2'(md), a, b, m, ref_op(2'(md), a, b, m, w));
                wait_done(sel, cyc, bcyc);
                e = sb.pop_front();
                n_total++; if (cyc != lat) $display("FAIL rand%0d_latency m%0d[%0d]: got %0d expected %0d", sel, md, i, cyc, lat); else n_pass++;
                n_total++; if (get_res(sel) !== e.res) $display("FAIL rand%0d_result m%0d[%0d]: got %h expected %h", sel, md, i, get_res(sel), e.res); else n_pass++;
                n_total++; if (flag_v[sel] !== e.flag) $display("FAIL rand%0d_flag m%0d[%0d]: got %b expected %b", sel, md, i, flag_v[sel], e.flag); else n_pass++;
            end
        end
    endtask

    // start pulses during RUN and during FINAL must be dropped.
    task automatic test_busy_ignore();
        exp_t e;
        int   ndone;
        int   dcyc;
        drive_op(0, 2'b10, MW'(5), MW'(4), MW'(7), '{MW'(2), 1'b1});
        ndone = 0;
        dcyc  = -1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (done_v[0]) begin
                ndone++;
                if (dcyc < 0) dcyc = i;
            end
            if (i == 3 || i == 9) begin
                mode       = 2'b00;
                in_a       = 513'd100;
                in_b       = 513'd200;
                start_v[0] = 1'b1;
            end else begin
                start_v[0] = 1'b0;
            end
        end
        e = sb.pop_front();
        n_total++; if (ndone != 1) $display("FAIL ignore_done_count: got %0d expected 1", ndone); else n_pass++;
        n_total++; if (dcyc != 10) $display("FAIL ignore_done_cycle: got %0d expected 10", dcyc); else n_pass++;
        n_total++; if (busy_v[0] !== 1'b0) $display("FAIL ignore_busy: got %b expected 0", busy_v[0]); else n_pass++;
        n_total++; if (get_res(0) !== e.res) $display("FAIL ignore_result: got %h expected %h", get_res(0), e.res); else n_pass++;
        n_total++; if (flag_v[0] !== e.flag) $display("FAIL ignore_flag: got %b expected %b", flag_v[0], e.flag); else n_pass++;
    endtask

    // start held high: operations every 11 cycles, operands changed after each done.
    task automatic test_back_to_back();
        logic [MW-1:0] ones;
        logic [MW-1:0] av[3];
        logic [MW-1:0] bv[3];
        logic [1:0]    mv[3];
        exp_t          e;
        int            ndone;
        ones = (MW'(1) << W0) - MW'(1);
        av = '{MW'(10), MW'(3), ones};
        bv = '{MW'(20), MW'(7), MW'(1)};
        mv = '{2'b00, 2'b01, 2'b00};
        @(negedge clk);
        mode = mv[0]; in_a = av[0][W0-1:0]; in_b = bv[0][W0-1:0]; modulus = '0;
        start_v[0] = 1'b1;
        sb.push_back(ref_op(mv[0], av[0], bv[0], MW'(0), W0));
        ndone = 0;
        for (int i = 0; i <= 50 && ndone < 3; i++) begin
            @(negedge clk);
            if (done_v[0]) begin
                e = sb.pop_front();
                n_total++; if (i != 10 + 11 * ndone) $display("FAIL b2b_done_cycle[%0d]: got %0d expected %0d", ndone, i, 10 + 11 * ndone); else n_pass++;
                n_total++; if (get_res(0) !== e.res) $display("FAIL b2b_result[%0d]: got %h expected %h", ndone, get_res(0), e.res); else n_pass++;
                n_total++; if (flag_v[0] !== e.flag) $display("FAIL b2b_flag[%0d]: got %b expected %b", ndone, flag_v[0], e.flag); else n_pass++;
                ndone++;
                if (ndone < 3) begin
                    mode = mv[ndone]; in_a = av[ndone][W0-1:0]; in_b = bv[ndone][W0-1:0];
                    sb.push_back(ref_op(mv[ndone], av[ndone], bv[ndone], MW'(0), W0));
                end
            end
            if (i == 22) start_v[0] = 1'b0;
        end
        start_v[0] = 1'b0;
        n_total++; if (ndone != 3) $display("FAIL b2b_count: got %0d expected 3", ndone); else n_pass++;
        sb.delete();
    endtask

    // Reset during RUN clears outputs, drops the operation, and the next one works.
    task automatic test_reset_mid();
        exp_t e;
        int   ndone;
        int   cyc;
        int   bcyc;
        @(negedge clk);
        mode = 2'b00; in_a = 513'd3; in_b = 513'd4;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        #1;
        n_total++; if (result0 !== '0) $display("FAIL midrst_result: got %h expected 0", result0); else n_pass++;
        n_total++; if (flag_v[0] !== 1'b0) $display("FAIL midrst_flag: got %b expected 0", flag_v[0]); else n_pass++;
        n_total++; if (busy_v[0] !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy_v[0]); else n_pass++;
        n_total++; if (done_v[0] !== 1'b0) $display("FAIL midrst_done: got %b expected 0", done_v[0]); else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done_v[0]) ndone++;
        end
        n_total++; if (ndone != 0) $display("FAIL midrst_no_done: got %0d expected 0", ndone); else n_pass++;
        drive_op(0, 2'b01, MW'(9), MW'(4), MW'(0), '{MW'(5), 1'b0});
        wait_done(0, cyc, bcyc);
        e = sb.pop_front();
        n_total++; if (cyc != 10) $display("FAIL midrst_latency: got %0d expected 10", cyc); else n_pass++;
        n_total++; if (get_res(0) !== e.res) $display("FAIL midrst_result_after: got %h expected %h", get_res(0), e.res); else n_pass++;
        n_total++; if (flag_v[0] !== e.flag) $display("FAIL midrst_flag_after: got %b expected %b", flag_v[0], e.flag); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_modular();
        test_random(0, W0, 10, 25);
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random(1, W1, 5, 1000);
        test_random(2, W2, 2, 1000);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
